// File: rtl/tp_pair_operand_stage.sv
// tp_pair_operand_stage: two-stage stallable operand prep for the 18s x 17s tracklet multiplier
//   ap_clk / ap_rst_n           clock (rising edge) and asynchronous active-low reset
//   cnt_clr                     synchronous clear of all statistics counters
//   in_valid / in_ready         input pair handshake (in_ready does not depend on in_valid)
//   in_phi_i/o, in_r_i/o        inner/outer stub phi and r, unsigned
//   in_invdr, in_last           looked-up signed 1/dr factor, last pair of event
//   mul_din0 / mul_din1         saturated scaled dphi / invdr operands
//   out_valid / out_ready       output handshake, out_last marks end of event
//   cnt_pairs/cnt_rej/cnt_sat   saturating counters: accepted, dr-rejected, dphi-saturated
module tp_pair_operand_stage #(
  parameter int PHI_W     = 14,
  parameter int R_W       = 12,
  parameter int PHI_SHIFT = 4,
  parameter int DR_MIN    = 1,
  parameter int DR_MAX    = 1023,
  parameter int CNT_W     = 16
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             cnt_clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PHI_W-1:0] in_phi_i,
  input  logic [PHI_W-1:0] in_phi_o,
  input  logic [R_W-1:0]   in_r_i,
  input  logic [R_W-1:0]   in_r_o,
  input  logic [16:0]      in_invdr,
  input  logic             in_last,
  output logic [17:0]      mul_din0,
  output logic [16:0]      mul_din1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [CNT_W-1:0] cnt_pairs,
  output logic [CNT_W-1:0] cnt_rej,
  output logic [CNT_W-1:0] cnt_sat
);
  logic                          s1_valid_q, s1_valid_d, s1_last_q;
  logic [PHI_W-1:0]              s1_phi_i_q, s1_phi_o_q;
  logic [R_W-1:0]                s1_r_i_q, s1_r_o_q;
  logic [16:0]                   s1_invdr_q;
  logic                          s2_valid_q, s2_valid_d, s2_last_q;
  logic [17:0]                   s2_din0_q;
  logic [16:0]                   s2_din1_q;
  logic [CNT_W-1:0]              cnt_pairs_q, cnt_rej_q, cnt_sat_q;
  logic signed [R_W:0]           dr;
  logic signed [PHI_W:0]         dphi;
  logic signed [PHI_W+PHI_SHIFT:0] sh;
  logic                          s1_adv, xfer_in, rej, sat_hi, sat_lo, sat, s2_load;
  logic [17:0]                   din0_sat;

  assign s1_adv   = s1_valid_q & (!s2_valid_q | out_ready);
  assign in_ready = !s1_valid_q | s1_adv;
  assign xfer_in  = in_valid & in_ready;

  // zero-extend before subtracting so differences never wrap modulo the field width
  assign dr   = $signed({1'b0, s1_r_o_q}) - $signed({1'b0, s1_r_i_q});
  assign dphi = $signed({1'b0, s1_phi_o_q}) - $signed({1'b0, s1_phi_i_q});
  assign sh   = {dphi, {PHI_SHIFT{1'b0}}};

  assign rej      = int'(dr) < DR_MIN || int'(dr) > DR_MAX;
  assign sat_hi   = int'(sh) > 131071;
  assign sat_lo   = int'(sh) < -131072;
  // a rejected pair drives zero operands, so it never counts as saturated
  assign sat      = !rej & (sat_hi | sat_lo);
  assign din0_sat = sat_hi ? 18'h1ffff : sat_lo ? 18'h20000 : sh[17:0];

  // rejected non-last pairs vanish; a rejected last pair still carries the event boundary
  assign s2_load    = s1_adv & (!rej | s1_last_q);
  assign s1_valid_d = xfer_in | (s1_valid_q & !s1_adv);
  assign s2_valid_d = s2_load | (s2_valid_q & !out_ready);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_phi_i_q <= '0;
      s1_phi_o_q <= '0;
      s1_r_i_q   <= '0;
      s1_r_o_q   <= '0;
      s1_invdr_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (xfer_in) begin
        s1_last_q  <= in_last;
        s1_phi_i_q <= in_phi_i;
        s1_phi_o_q <= in_phi_o;
        s1_r_i_q   <= in_r_i;
        s1_r_o_q   <= in_r_o;
        s1_invdr_q <= in_invdr;
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_din0_q  <= '0;
      s2_din1_q  <= '0;
    end else begin
      s2_valid_q <= s2_valid_d;
      if (s2_load) begin
        s2_last_q <= s1_last_q;
        s2_din0_q <= rej ? '0 : din0_sat;
        s2_din1_q <= rej ? '0 : s1_invdr_q;
      end
    end
  end

  // clear wins over increment; each counter sticks at all-ones
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cnt_pairs_q <= '0;
      cnt_rej_q   <= '0;
      cnt_sat_q   <= '0;
    end else begin
      cnt_pairs_q <= cnt_clr ? '0 : cnt_pairs_q + CNT_W'(xfer_in && !(&cnt_pairs_q));
      cnt_rej_q   <= cnt_clr ? '0 : cnt_rej_q + CNT_W'(s1_adv && rej && !(&cnt_rej_q));
      cnt_sat_q   <= cnt_clr ? '0 : cnt_sat_q + CNT_W'(s1_adv && sat && !(&cnt_sat_q));
    end
  end

  assign out_valid = s2_valid_q;
  assign out_last  = s2_last_q;
  assign mul_din0  = s2_din0_q;
  assign mul_din1  = s2_din1_q;
  assign cnt_pairs = cnt_pairs_q;
  assign cnt_rej   = cnt_rej_q;
  assign cnt_sat   = cnt_sat_q;
endmodule

// File: tb/tb_tp_pair_operand_stage.sv
// tb_tp_pair_operand_stage: directed and randomized checks of the pair operand stage against a scoreboard
module tb_tp_pair_operand_stage;
  logic        ap_clk = 1'b0, ap_rst_n = 1'b0, cnt_clr = 1'b0;
  logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [13:0] in_phi_i = '0, in_phi_o = '0;
  logic [11:0] in_r_i = '0, in_r_o = '0;
  logic [16:0] in_invdr = '0;
  logic        in_ready, out_valid, out_last;
  logic [17:0] mul_din0;
  logic [16:0] mul_din1;
  logic [15:0] cnt_pairs, cnt_rej, cnt_sat;

  typedef struct packed {logic last; logic [16:0] d1; logic [17:0] d0;} beat_t;
  beat_t q[$];
  int checks = 0, failures = 0, beats = 0;
  int exp_pairs = 0, exp_rej = 0, exp_sat = 0;

  tp_pair_operand_stage dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .cnt_clr(cnt_clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_phi_i(in_phi_i), .in_phi_o(in_phi_o), .in_r_i(in_r_i), .in_r_o(in_r_o),
    .in_invdr(in_invdr), .in_last(in_last),
    .mul_din0(mul_din0), .mul_din1(mul_din1),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .cnt_pairs(cnt_pairs), .cnt_rej(cnt_rej), .cnt_sat(cnt_sat)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge ap_clk);
    #1;
  endtask

  task automatic drive(input int pi, input int po, input int ri, input int ro, input int iv, input logic l);
    in_phi_i = 14'(pi);
    in_phi_o = 14'(po);
    in_r_i   = 12'(ri);
    in_r_o   = 12'(ro);
    in_invdr = 17'(iv);
    in_last  = l;
    in_valid = 1'b1;
  endtask

  task automatic send(input int pi, input int po, input int ri, input int ro, input int iv, input logic l);
    int n = 0;
    drive(pi, po, ri, ro, iv, l);
    @(negedge ap_clk);
    while (!in_ready && n < 100) begin
      @(negedge ap_clk);
      n++;
    end
    if (n >= 100) check("send_timeout", 0, 1);
    @(posedge ap_clk);
    #1 in_valid = 1'b0;
  endtask

  initial begin : monitor
    int dr, dp, sh;
    logic rj, st;
    beat_t b;
    forever begin
      @(negedge ap_clk);
      if (!ap_rst_n) begin
        q.delete();
        exp_pairs = 0;
        exp_rej = 0;
        exp_sat = 0;
      end else begin
        if (out_valid && out_ready) begin
          beats++;
          if (q.size() == 0) check("sb_extra_beat", 1, 0);
          else check("sb_beat", {out_last, mul_din1, mul_din0}, q.pop_front());
        end
        if (cnt_clr) begin
          exp_pairs = 0;
          exp_rej = 0;
          exp_sat = 0;
        end
        if (in_valid && in_ready) begin
          dr = int'(in_r_o) - int'(in_r_i);
          dp = int'(in_phi_o) - int'(in_phi_i);
          sh = dp * 16;
          rj = dr < 1 || dr > 1023;
          st = !rj && (sh > 131071 || sh < -131072);
          b.last = in_last;
          b.d1 = rj ? 17'd0 : in_invdr;
          b.d0 = rj ? 18'd0 : sh > 131071 ? 18'h1ffff : sh < -131072 ? 18'h20000 : 18'(sh);
          if (!cnt_clr) begin
            exp_pairs++;
            exp_rej += int'(rj);
            exp_sat += int'(st);
          end
          if (!rj || in_last) q.push_back(b);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, bs, iters, sent;
    logic acc;
    logic [35:0] s0;
    #23 ap_rst_n = 1'b1;
    tick(1);
    check("rst_out_valid", out_valid, 0);
    check("rst_din0", mul_din0, 0);
    check("rst_din1", mul_din1, 0);
    check("rst_last", out_last, 0);
    check("rst_cnt_pairs", cnt_pairs, 0);
    check("rst_cnt_rej", cnt_rej, 0);
    check("rst_cnt_sat", cnt_sat, 0);
    check("rst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    send(100, 110, 200, 300, 655, 0);
    check("t1_lat1", out_valid, 0);
    tick(1);
    check("t1_valid", out_valid, 1);
    check("t1_din0", mul_din0, 18'd160);
    check("t1_din1", mul_din1, 17'd655);
    tick(1);
    send(0, 16383, 200, 300, 1, 0);
    tick(1);
    check("t2_sat_hi", mul_din0, 18'h1ffff);
    check("t2_cnt_sat1", cnt_sat, 1);
    send(16383, 0, 200, 300, 2, 0);
    tick(1);
    check("t2_sat_lo", mul_din0, 18'h20000);
    check("t2_cnt_sat2", cnt_sat, 2);
    tick(1);
    send(100, 110, 300, 300, 3, 0);
    tick(3);
    check("t3_drop", out_valid, 0);
    check("t3_cnt_rej1", cnt_rej, 1);
    send(100, 110, 300, 300, 3, 1);
    tick(1);
    check("t3_last_valid", out_valid, 1);
    check("t3_last_flag", out_last, 1);
    check("t3_last_din0", mul_din0, 0);
    check("t3_last_din1", mul_din1, 0);
    check("t3_cnt_rej2", cnt_rej, 2);
    tick(2);
    drive(100, 110, 200, 300, 4, 0);
    cnt_clr = 1'b1;
    tick(1);
    in_valid = 1'b0;
    cnt_clr = 1'b0;
    check("clr_cnt_pairs", cnt_pairs, 0);
    check("clr_cnt_rej", cnt_rej, 0);
    check("clr_cnt_sat", cnt_sat, 0);
    tick(2);
    out_ready = 1'b0;
    k = 0;
    repeat (6) begin
      drive(100, 101 + 3 * k, 10, 20, 10 + k, k == 7);
      @(negedge ap_clk);
      acc = in_ready;
      tick(1);
      if (acc) k++;
    end
    in_valid = 1'b0;
    check("t4_accepted", k, 2);
    check("t4_in_ready", in_ready, 0);
    check("t4_out_valid", out_valid, 1);
    check("t4_head_din0", mul_din0, 18'd16);
    s0 = {out_last, mul_din1, mul_din0};
    tick(3);
    check("t4_stable", {out_last, mul_din1, mul_din0}, s0);
    bs = beats;
    out_ready = 1'b1;
    while (k < 8) begin
      send(100, 101 + 3 * k, 10, 20, 10 + k, k == 7);
      k++;
    end
    tick(2);
    check("t4_throughput", beats - bs, 8);
    sent = 0;
    iters = 0;
    while (sent < 10000 && iters < 50000) begin
      if (!in_valid && $urandom_range(3) != 0) begin
        k = int'($urandom_range(4095));
        drive(int'($urandom_range(16383)), int'($urandom_range(16383)), k,
              k + int'($urandom_range(1100)) - 50, int'($urandom_range(131071)),
              $urandom_range(15) == 0);
      end
      out_ready = $urandom_range(3) != 0;
      @(negedge ap_clk);
      acc = in_valid && in_ready;
      tick(1);
      if (acc) begin
        sent++;
        in_valid = 1'b0;
      end
      iters++;
    end
    check("t5_sent", sent, 10000);
    out_ready = 1'b1;
    in_valid = 1'b0;
    tick(6);
    check("t5_drained", q.size(), 0);
    check("t5_cnt_pairs", cnt_pairs, 16'(exp_pairs));
    check("t5_cnt_rej", cnt_rej, 16'(exp_rej));
    check("t5_cnt_sat", cnt_sat, 16'(exp_sat));
    out_ready = 1'b0;
    send(100, 120, 200, 300, 5, 0);
    send(100, 130, 200, 300, 6, 0);
    #2 ap_rst_n = 1'b0;
    #1;
    check("t6_out_valid", out_valid, 0);
    check("t6_cnt_pairs", cnt_pairs, 0);
    check("t6_in_ready", in_ready, 1);
    #20 ap_rst_n = 1'b1;
    tick(1);
    out_ready = 1'b1;
    send(100, 110, 200, 300, 7, 0);
    check("t6_lat1", out_valid, 0);
    tick(1);
    check("t6_valid", out_valid, 1);
    check("t6_din0", mul_din0, 18'd160);
    check("t6_din1", mul_din1, 17'd7);
    tick(2);
    check("t6_no_extra", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
